// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
// Holds the slice width, the FSM state encoding and the index-width helper.
package multiword_add_sequencer_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder built from four 4-bit blocks.
// Each upper block precomputes both carry-in cases and the chain selects.
module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] s0 [4];
  logic [4:0] s1 [4];
  logic       c;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    assign s0[g] = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]};
    assign s1[g] = {1'b0, a[g*4 +: 4]} + {1'b0, b[g*4 +: 4]} + 5'd1;
  end

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i*4 +: 4] = c ? s1[i][3:0] : s0[i][3:0];
      c             = c ? s1[i][4]   : s0[i][4];
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds or subtracts WORDS*16-bit operands one 16-bit slice per clock,
// LSB slice first, through a single carry-select adder core.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORDS*SLICE_W-1:0] a,
  input  logic [WORDS*SLICE_W-1:0] b,
  input  logic                     cin,
  input  logic                     op_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORDS*SLICE_W-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W  = WORDS * SLICE_W;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  assign sl_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign sl_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  carry_select_adder_16bit u_adder (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          // subtract is A + ~B + 1, so invert B once at accept
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          a_msb_d = a[W-1];
          b_msb_d = op_sub ? ~b[W-1] : b[W-1];
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        if (idx_q == LAST) begin
          cout_d  = sl_cout;
          ovf_d   = (a_msb_q == b_msb_q) &&
                    (sl_sum[SLICE_W-1] != a_msb_q);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: directed table, corner sequences and random ops
// against a width-generic reference model, for WORDS=4 and WORDS=1.
`timescale 1ns/1ps
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, op_sub, cout, overflow;

  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0]  a1, b1, sum1;
  logic         cin1, op_sub1, cout1, overflow1;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  multiword_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .op_sub(op_sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .overflow(overflow1)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nbad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts, input int n);
    logic [W:0]   full;
    logic [W-1:0] m, be;
    exp_t         e;
    m    = (n >= W) ? '1 : ((W'(1) << n) - W'(1));
    be   = (ts ? ~tb : tb) & m;
    full = {1'b0, ta & m} + {1'b0, be} + {64'd0, (ts ? 1'b1 : tc)};
    e.s  = full[W-1:0] & m;
    e.co = full[n];
    e.ov = (ta[n-1] == be[n-1]) && (e.s[n-1] != ta[n-1]);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts, input exp_t e);
    int n;
    n = 0;
    a = ta; b = tb; cin = tc; op_sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout("accept");
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input bit rnd, output int lat);
    exp_t e;
    lat = 0;
    while (lat < 100) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) break;
      tick();
      lat++;
    end
    if (lat >= 100) begin
      timeout("out_valid");
    end else begin
      e = sb.pop_front();
      check("sum", sum, e.s);
      check("cout", {63'd0, cout}, {63'd0, e.co});
      check("overflow", {63'd0, overflow}, {63'd0, e.ov});
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    exp_t e;
    int   lat;
    int   n;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               '{64'h0, 1'b1, 1'b0}};
    tbl[1] = '{64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1,
               '{64'h0000_0000_0000_FFFF, 1'b1, 1'b0}};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               '{64'h8000_0000_0000_0000, 1'b0, 1'b1}};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
               '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}};
    tbl[4] = '{64'h0, 64'h0, 1'b1, 1'b0,
               '{64'h1, 1'b0, 1'b0}};
    tbl[5] = '{64'h5, 64'h5, 1'b1, 1'b1,
               '{64'h0, 1'b1, 1'b0}};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0; op_sub1 = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e);
      recv(1'b0, lat);
      check("latency", 64'(lat), 64'(WORDS));
    end

    // backpressure: hold DONE for 10 cycles while inputs churn
    e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, W);
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, e);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op_sub = 1'($urandom_range(0, 1));
      tick();
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_sum", sum, e.s);
      check("bp_cout", {63'd0, cout}, {63'd0, e.co});
    end
    a = 64'h3; b = 64'h4; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    recv(1'b0, lat);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    send(64'h3, 64'h4, 1'b0, 1'b0, model(64'h3, 64'h4, 1'b0, 1'b0, W));
    recv(1'b0, lat);
    check("bp_next_latency", 64'(lat), 64'(WORDS));

    // reset after two slices, with in_valid held high during reset
    send(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0,
         model(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0, W));
    tick();
    tick();
    rst = 1'b1;
    in_valid = 1'b1;
    sb.delete();
    tick();
    check("midrun_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrun_sum", sum, 64'd0);
    check("midrun_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrun_in_ready_after", {63'd0, in_ready}, 64'd1);
    check("midrun_no_accept", {63'd0, out_valid}, 64'd0);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 50 == 0) ra = '1;
      if (i % 70 == 0) rb = {1'b1, 63'd0};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs, W));
      recv(1'b1, lat);
    end

    for (int i = 0; i < 1000; i++) begin
      exp_t e1;
      a1 = 16'($urandom);
      b1 = 16'($urandom);
      cin1 = 1'($urandom_range(0, 1));
      op_sub1 = 1'($urandom_range(0, 1));
      e1 = model({48'd0, a1}, {48'd0, b1}, cin1, op_sub1, 16);
      in_valid1 = 1'b1;
      n = 0;
      while (!in_ready1 && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) timeout("w1_accept");
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (lat < 100) begin
        out_ready1 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_valid1 && out_ready1) break;
        tick();
        lat++;
      end
      if (lat >= 100) begin
        timeout("w1_out_valid");
      end else begin
        if (i == 0) check("w1_latency", 64'(lat), 64'd1);
        check("w1_sum", {48'd0, sum1}, e1.s);
        check("w1_cout", {63'd0, cout1}, {63'd0, e1.co});
        check("w1_overflow", {63'd0, overflow1}, {63'd0, e1.ov});
        tick();
      end
      out_ready1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
